// File: rtl/k86_biu.sv
// ---------------------------------------------------------------------------
// k86_biu - bus interface unit for the k86 core.
//
// Owns the external memory bus. While the bus is free it keeps a byte-wide
// prefetch queue filled from CS:IP, and it serves single data accesses for
// the execution unit. A data request has priority over prefetching, and a
// jump has priority over both. The bus is 8 or 16 bits wide. Wait states are
// inserted by holding mem_ready low.
//
// Optional feature: define K86_BIU_WORDDATA_EN to add the d_word input.
// A word access on a 16-bit bus at an even offset takes one bus cycle. Any
// other word access takes two byte cycles, low byte first. Without the
// macro, every data access is a byte access.
//
// Ports
//   clock, reset_n   system clock; synchronous active-low reset
//   chipen           clock enable; 0 freezes all state
//   address          20-bit physical address of the current bus cycle
//   in / out         read data from memory / write data to memory
//   we, be           write strobe, byte-lane enables
//   mem_ready        the bus cycle completes on an edge where this is 1
//   bus_code         the current bus cycle is a code fetch
//   jmp, jmp_cs/ip   flush the queue and restart fetching at jmp_cs:jmp_ip
//   q_rd             pop the head byte of the queue
//   q_data, q_valid  head byte of the queue, queue not empty
//   q_ip             IP of the head byte
//   d_req            one-cycle data request; latched with d_we/d_seg/d_ea/
//                    d_wdata (and d_word)
//   d_rdata, d_done  read data (held), one-cycle completion pulse
// ---------------------------------------------------------------------------
module k86_biu #(
  parameter int          BUS_WIDTH   = 8,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [15:0] RESET_CS    = 16'hFFFF,
  parameter logic [15:0] RESET_IP    = 16'h0000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   chipen,
  output logic [19:0]            address,
  input  logic [BUS_WIDTH-1:0]   in,
  output logic [BUS_WIDTH-1:0]   out,
  output logic                   we,
  output logic [BUS_WIDTH/8-1:0] be,
  input  logic                   mem_ready,
  output logic                   bus_code,
  input  logic                   jmp,
  input  logic [15:0]            jmp_cs,
  input  logic [15:0]            jmp_ip,
  input  logic                   q_rd,
  output logic [7:0]             q_data,
  output logic                   q_valid,
  output logic [15:0]            q_ip,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [15:0]            d_seg,
  input  logic [15:0]            d_ea,
  input  logic [15:0]            d_wdata,
`ifdef K86_BIU_WORDDATA_EN
  input  logic                   d_word,
`endif
  output logic [15:0]            d_rdata,
  output logic                   d_done
);

  localparam int LANES = BUS_WIDTH / 8;
  localparam int AW    = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t state, next_state;

  // Fetch pointer and prefetch queue
  logic [15:0]   fcs, fip;
  logic [7:0]    q_mem [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          f_odd;             // fetch issued at an odd IP (16-bit bus)

  // Pending data request
  logic          pend, p_we, p_word, phase;
  logic [15:0]   p_seg, p_ea, p_wdata;
  logic [7:0]    lo_byte;           // low byte of a split word read
  logic          word_in;

  // Decoded control
  logic          start_fetch, start_data, fetch_done, data_done;
  logic          room, pop, word_one, split, last;
  logic [15:0]   d_off;
  logic [19:0]   d_addr, f_addr;
  logic [7:0]    wbyte, rbyte, push0, push1;
  logic [1:0]    push_n;

`ifdef K86_BIU_WORDDATA_EN
  assign word_in = d_word;
`else
  assign word_in = 1'b0;
`endif

  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  // Lane enable for a single byte at an address whose bit 0 is a0.
  function automatic logic [LANES-1:0] lane_be(input logic a0);
    if (LANES == 1) return '1;
    return LANES'({a0, ~a0});
  endfunction

  // Byte from the high (hi=1) or low lane. An 8-bit bus has only one lane.
  function automatic logic [7:0] lane_byte(input logic [BUS_WIDTH-1:0] d, input logic hi);
    logic [15:0] w;
    w = 16'(d);
    return (LANES == 2 && hi) ? w[15:8] : w[7:0];
  endfunction

  assign q_data  = q_mem[rd_ptr];
  assign q_valid = (count != '0);
  assign room    = (int'(count) + LANES) <= QUEUE_DEPTH;
  assign pop     = q_rd && q_valid && !jmp;

  // A word access on a 16-bit bus at an even offset fits one cycle. Any
  // other word access is split into two byte cycles.
  assign word_one = (LANES == 2) && p_word && !p_ea[0];
  assign split    = p_word && !word_one;
  assign last     = !split || phase;
  assign d_off    = p_ea + {15'h0000, phase};
  assign d_addr   = phys(p_seg, d_off);
  assign wbyte    = (split && phase) ? p_wdata[15:8] : p_wdata[7:0];
  assign rbyte    = lane_byte(in, address[0]);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    start_fetch = 1'b0;
    start_data  = 1'b0;
    fetch_done  = 1'b0;
    data_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!jmp) begin
          if (pend) begin
            start_data = 1'b1;
            next_state = DATA;
          end else if (room) begin
            start_fetch = 1'b1;
            next_state  = FETCH;
          end
        end
      end
      FETCH: begin
        if (jmp) begin
          next_state = IDLE;               // abort, returned data is dropped
        end else if (mem_ready) begin
          fetch_done = 1'b1;
          next_state = IDLE;
        end
      end
      DATA: begin
        // A jump never aborts a data cycle.
        if (mem_ready) begin
          data_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Fetch address and the bytes a completing fetch pushes.
  always_comb begin
    f_addr = phys(fcs, fip);
    if (LANES == 2) f_addr[0] = 1'b0;
    push_n = 2'd0;
    push0  = 8'h00;
    push1  = 8'h00;
    if (fetch_done) begin
      if (LANES == 1) begin
        push_n = 2'd1;
        push0  = lane_byte(in, 1'b0);
      end else if (f_odd) begin
        push_n = 2'd1;
        push0  = lane_byte(in, 1'b1);
      end else begin
        push_n = 2'd2;
        push0  = lane_byte(in, 1'b0);
        push1  = lane_byte(in, 1'b1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else if (chipen) state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      address  <= '0;
      out      <= '0;
      we       <= 1'b0;
      be       <= '0;
      bus_code <= 1'b0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
      fcs      <= RESET_CS;
      fip      <= RESET_IP;
      q_ip     <= RESET_IP;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      f_odd    <= 1'b0;
      pend     <= 1'b0;
      p_we     <= 1'b0;
      p_word   <= 1'b0;
      phase    <= 1'b0;
      p_seg    <= '0;
      p_ea     <= '0;
      p_wdata  <= '0;
      lo_byte  <= '0;
    end else if (chipen) begin
      d_done <= 1'b0;

      // A request that arrives while one is pending is dropped.
      if (d_req && !pend) begin
        pend    <= 1'b1;
        p_we    <= d_we;
        p_word  <= word_in;
        p_seg   <= d_seg;
        p_ea    <= d_ea;
        p_wdata <= d_wdata;
        phase   <= 1'b0;
      end

      if (start_fetch) begin
        address  <= f_addr;
        we       <= 1'b0;
        be       <= fip[0] ? lane_be(1'b1) : '1;
        bus_code <= 1'b1;
        f_odd    <= fip[0];
      end

      if (start_data) begin
        address  <= d_addr;
        we       <= p_we;
        bus_code <= 1'b0;
        if (word_one) begin
          be  <= '1;
          out <= BUS_WIDTH'(p_wdata);
        end else begin
          be  <= lane_be(d_addr[0]);
          out <= {LANES{wbyte}};       // byte replicated on every lane
        end
      end

      if (fetch_done || (state == FETCH && jmp)) begin
        be       <= '0;
        bus_code <= 1'b0;
      end
      if (fetch_done) fip <= fip + 16'(push_n);

      if (data_done) begin
        we <= 1'b0;
        be <= '0;
        if (!last) begin
          phase   <= 1'b1;
          lo_byte <= rbyte;
        end else begin
          pend   <= 1'b0;
          d_done <= 1'b1;
          if (!p_we) begin
            if (word_one)   d_rdata <= 16'(in);
            else if (split) d_rdata <= {rbyte, lo_byte};
            else            d_rdata <= {8'h00, rbyte};
          end
        end
      end

      if (jmp) begin
        fcs    <= jmp_cs;
        fip    <= jmp_ip;
        q_ip   <= jmp_ip;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(push_n);
        count  <= count + (AW+1)'(push_n) - (AW+1)'(pop);
        if (pop) q_ip <= q_ip + 16'h0001;
      end
    end
  end

  // NOTE: the queue storage has no reset. The count and pointers decide
  // which entries are valid, so stale bytes are never visible.
  always_ff @(posedge clock) begin
    if (reset_n && chipen && push_n != 2'd0) begin
      q_mem[wr_ptr] <= push0;
      if (push_n == 2'd2) q_mem[wr_ptr + AW'(1)] <= push1;
    end
  end

endmodule

// File: tb/tb_k86_biu.sv
// ---------------------------------------------------------------------------
// tb_k86_biu - self-checking bench for k86_biu.
// An 8-bit-bus instance (index 0) and a 16-bit-bus instance (index 1) share
// one stimulus stream. A transaction-level model predicts both instances and
// is compared on every cycle. Directed scenarios pin the model with literal
// expectations. A randomized run follows.
// ---------------------------------------------------------------------------
module tb_k86_biu;

  localparam int DEPTH = 4;
`ifdef K86_BIU_WORDDATA_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #20 clock = ~clock;

  logic        reset_n, chipen, mem_ready, jmp, q_rd, d_req, d_we, d_word;
  logic [15:0] jmp_cs, jmp_ip, d_seg, d_ea, d_wdata;
  logic [7:0]  in8;
  logic [15:0] in16;

  logic [19:0] address8, address16;
  logic [7:0]  out8, q_data8, q_data16;
  logic [15:0] out16, q_ip8, q_ip16, d_rdata8, d_rdata16;
  logic        we8, we16, bus_code8, bus_code16, q_valid8, q_valid16, d_done8, d_done16;
  logic [0:0]  be8;
  logic [1:0]  be16;

  k86_biu #(.BUS_WIDTH(8), .QUEUE_DEPTH(DEPTH)) u8 (
    .clock(clock), .reset_n(reset_n), .chipen(chipen), .address(address8),
    .in(in8), .out(out8), .we(we8), .be(be8), .mem_ready(mem_ready),
    .bus_code(bus_code8), .jmp(jmp), .jmp_cs(jmp_cs), .jmp_ip(jmp_ip),
    .q_rd(q_rd), .q_data(q_data8), .q_valid(q_valid8), .q_ip(q_ip8),
    .d_req(d_req), .d_we(d_we), .d_seg(d_seg), .d_ea(d_ea), .d_wdata(d_wdata),
`ifdef K86_BIU_WORDDATA_EN
    .d_word(d_word),
`endif
    .d_rdata(d_rdata8), .d_done(d_done8)
  );

  k86_biu #(.BUS_WIDTH(16), .QUEUE_DEPTH(DEPTH)) u16 (
    .clock(clock), .reset_n(reset_n), .chipen(chipen), .address(address16),
    .in(in16), .out(out16), .we(we16), .be(be16), .mem_ready(mem_ready),
    .bus_code(bus_code16), .jmp(jmp), .jmp_cs(jmp_cs), .jmp_ip(jmp_ip),
    .q_rd(q_rd), .q_data(q_data16), .q_valid(q_valid16), .q_ip(q_ip16),
    .d_req(d_req), .d_we(d_we), .d_seg(d_seg), .d_ea(d_ea), .d_wdata(d_wdata),
`ifdef K86_BIU_WORDDATA_EN
    .d_word(d_word),
`endif
    .d_rdata(d_rdata16), .d_done(d_done16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory contents seen by both bus widths.
  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    if (a == 20'h00100) return 8'hC3;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h0, a[19:16]} ^ 8'h96;
  endfunction

  // ---------------- transaction-level model (index 0: 8-bit, 1: 16-bit) ----
  logic [15:0] m_cs[2], m_ip[2], m_qip[2];
  logic [7:0]  m_qb[2][DEPTH];
  int          m_qn[2];
  int          m_kind[2];            // bus transaction: 0 none, 1 code, 2 data
  logic [19:0] m_addr[2];
  logic        m_we[2], m_code[2], m_done[2];
  logic [1:0]  m_be[2];
  logic [15:0] m_out[2], m_rdata[2];
  logic        m_pend[2], m_pwe[2], m_pword[2], m_half[2];
  logic [15:0] m_pseg[2], m_pea[2], m_pwd[2];
  logic [7:0]  m_lo[2];

  task automatic model_step(input int k, input logic [15:0] din);
    logic        was_idle, old_pend, wone, split;
    int          old_n, fn;
    logic [7:0]  b, fb0, fb1;
    logic [15:0] off;
    logic [19:0] a;
    if (!reset_n) begin
      m_cs[k] = 16'hFFFF; m_ip[k] = 16'h0000; m_qip[k] = 16'h0000; m_qn[k] = 0;
      m_kind[k] = 0; m_addr[k] = '0; m_we[k] = 0; m_be[k] = 0; m_out[k] = 0;
      m_code[k] = 0; m_done[k] = 0; m_rdata[k] = 0; m_pend[k] = 0; m_half[k] = 0;
      return;
    end
    if (!chipen) return;
    was_idle = (m_kind[k] == 0);
    old_pend = m_pend[k];
    old_n    = m_qn[k];
    fn = 0; fb0 = 0; fb1 = 0;
    m_done[k] = 0;
    wone  = (k == 1) && m_pword[k] && !m_pea[k][0];
    split = m_pword[k] && !wone;
    if (m_kind[k] == 1) begin
      if (jmp) begin
        m_kind[k] = 0; m_be[k] = 0; m_code[k] = 0;
      end else if (mem_ready) begin
        if (k == 0)          begin fn = 1; fb0 = din[7:0]; end
        else if (m_ip[k][0]) begin fn = 1; fb0 = din[15:8]; end
        else                 begin fn = 2; fb0 = din[7:0]; fb1 = din[15:8]; end
        m_ip[k] = m_ip[k] + 16'(fn);
        m_kind[k] = 0; m_be[k] = 0; m_code[k] = 0;
      end
    end else if (m_kind[k] == 2 && mem_ready) begin
      m_kind[k] = 0; m_we[k] = 0; m_be[k] = 0;
      b = (k == 1 && m_addr[k][0]) ? din[15:8] : din[7:0];
      if (split && !m_half[k]) begin
        m_half[k] = 1; m_lo[k] = b;
      end else begin
        m_pend[k] = 0; m_done[k] = 1;
        if (!m_pwe[k]) m_rdata[k] = wone ? din : (split ? {b, m_lo[k]} : {8'h00, b});
      end
    end
    if (q_rd && old_n > 0 && !jmp) begin
      for (int i = 0; i < DEPTH - 1; i++) m_qb[k][i] = m_qb[k][i+1];
      m_qn[k]--;
      m_qip[k]++;
    end
    if (fn >= 1) begin m_qb[k][m_qn[k]] = fb0; m_qn[k]++; end
    if (fn == 2) begin m_qb[k][m_qn[k]] = fb1; m_qn[k]++; end
    if (jmp) begin
      m_qn[k] = 0; m_cs[k] = jmp_cs; m_ip[k] = jmp_ip; m_qip[k] = jmp_ip;
    end
    if (was_idle && !jmp) begin
      if (old_pend) begin
        off = m_pea[k] + {15'h0, m_half[k]};
        a   = {m_pseg[k], 4'h0} + {4'h0, off};
        if (wone) begin
          m_be[k] = 2'b11; m_out[k] = m_pwd[k];
        end else begin
          b = (split && m_half[k]) ? m_pwd[k][15:8] : m_pwd[k][7:0];
          m_out[k] = (k == 1) ? {b, b} : {8'h00, b};
          m_be[k]  = (k == 0) ? 2'b01 : (a[0] ? 2'b10 : 2'b01);
        end
        m_addr[k] = a; m_we[k] = m_pwe[k]; m_code[k] = 0; m_kind[k] = 2;
      end else if (DEPTH - old_n >= k + 1) begin
        a = {m_cs[k], 4'h0} + {4'h0, m_ip[k]};
        if (k == 1) a[0] = 1'b0;
        m_addr[k] = a;
        m_be[k]   = (k == 0) ? 2'b01 : (m_ip[k][0] ? 2'b10 : 2'b11);
        m_we[k] = 0; m_code[k] = 1; m_kind[k] = 1;
      end
    end
    if (d_req && !old_pend) begin
      m_pend[k] = 1; m_pwe[k] = d_we; m_pseg[k] = d_seg; m_pea[k] = d_ea;
      m_pwd[k] = d_wdata; m_pword[k] = WORD_EN && d_word; m_half[k] = 0;
    end
  endtask

  task automatic compare(input int k);
    string       p;
    logic [19:0] a;
    logic [15:0] o, qi, rd;
    logic [7:0]  qd;
    logic [1:0]  b;
    logic        w, c, dn, qv;
    if (k == 0) begin
      p = "u8"; a = address8; o = {8'h00, out8}; w = we8; b = {1'b0, be8}; c = bus_code8;
      dn = d_done8; rd = d_rdata8; qv = q_valid8; qd = q_data8; qi = q_ip8;
    end else begin
      p = "u16"; a = address16; o = out16; w = we16; b = be16; c = bus_code16;
      dn = d_done16; rd = d_rdata16; qv = q_valid16; qd = q_data16; qi = q_ip16;
    end
    check({p, ".we"}, 32'(w), 32'(m_we[k]));
    check({p, ".be"}, 32'(b), 32'(m_be[k]));
    check({p, ".bus_code"}, 32'(c), 32'(m_code[k]));
    check({p, ".d_done"}, 32'(dn), 32'(m_done[k]));
    check({p, ".d_rdata"}, 32'(rd), 32'(m_rdata[k]));
    check({p, ".q_valid"}, 32'(qv), 32'(m_qn[k] > 0));
    check({p, ".q_ip"}, 32'(qi), 32'(m_qip[k]));
    if (m_kind[k] != 0) check({p, ".address"}, 32'(a), 32'(m_addr[k]));
    if (m_kind[k] == 2 && m_we[k]) check({p, ".out"}, 32'(o), 32'(m_out[k]));
    if (m_qn[k] > 0) check({p, ".q_data"}, 32'(qd), 32'(m_qb[k][0]));
  endtask

  // Called at a negedge with inputs set. Memory answers the address each
  // instance is expected to present, then one clock edge is taken.
  task automatic tick();
    in8  = mem_byte(m_addr[0]);
    in16 = {mem_byte(m_addr[1] | 20'h1), mem_byte(m_addr[1] & ~20'h1)};
    model_step(0, {8'h00, in8});
    model_step(1, in16);
    @(posedge clock);
    @(negedge clock);
    compare(0);
    compare(1);
  endtask

  task automatic quiet();
    chipen = 1; mem_ready = 1; jmp = 0; q_rd = 0; d_req = 0; d_word = 0;
  endtask

  initial begin
    quiet();
    reset_n = 0; d_we = 0; jmp_cs = 0; jmp_ip = 0; d_seg = 0; d_ea = 0; d_wdata = 0;
    in8 = 0; in16 = 0;
    @(negedge clock);
    tick(); tick();
    check("rst.out", 32'(out16), 32'h0);
    check("rst.be", 32'(be8), 32'h0);
    check("rst.q_ip", 32'(q_ip8), 32'h0000);
    check("rst.d_rdata", 32'(d_rdata16), 32'h0);

    // Prefetch from reset vector FFFF:0000.
    reset_n = 1;
    tick();
    check("boot.code", 32'(bus_code8), 32'h1);
    check("boot.be16", 32'(be16), 32'h3);
    for (int i = 0; i < 4; i++) begin
      check("boot.addr8", 32'(address8), 32'hFFFF0 + 32'(i));
      tick(); tick();
    end
    tick(); tick();
    check("boot.idle", 32'(be8), 32'h0);
    check("boot.q_valid", 32'(q_valid8), 32'h1);
    check("boot.q_ip", 32'(q_ip8), 32'h0000);
    check("boot.q_data", 32'(q_data16), 32'(mem_byte(20'hFFFF0)));

    // Jump to an odd IP: 16-bit bus enqueues the high lane only.
    jmp = 1; jmp_cs = 16'h1000; jmp_ip = 16'h0003;
    tick(); quiet();
    check("jmp.flush", 32'(q_valid16), 32'h0);
    tick();
    check("jmp.addr16", 32'(address16), 32'h10002);
    check("jmp.be16", 32'(be16), 32'h2);
    check("jmp.addr8", 32'(address8), 32'h10003);
    tick(); tick();
    check("jmp.next16", 32'(address16), 32'h10004);
    check("jmp.q_ip", 32'(q_ip16), 32'h0003);
    check("jmp.q_data", 32'(q_data16), 32'(mem_byte(20'h10003)));

    // Data write requested during a stalled fetch.
    d_req = 1; d_we = 1; d_seg = 16'h0200; d_ea = 16'h0010; d_wdata = 16'h115A; mem_ready = 0;
    tick(); quiet();
    tick(); tick();
    check("wr.addr8", 32'(address8), 32'h02010);
    check("wr.we8", 32'(we8), 32'h1);
    check("wr.out8", 32'(out8), 32'h5A);
    check("wr.out16", 32'(out16), 32'h5A5A);
    check("wr.be16", 32'(be16), 32'h1);
    tick();
    check("wr.done", 32'(d_done8), 32'h1);
    check("wr.we_off", 32'(we16), 32'h0);
    tick();
    check("wr.pulse", 32'(d_done16), 32'h0);

    // Read with three wait states.
    repeat (16) tick();
    d_req = 1; d_we = 0; d_seg = 16'h0010; d_ea = 16'h0000;
    tick(); quiet();
    tick();
    check("ws.addr", 32'(address8), 32'h00100);
    mem_ready = 0;
    repeat (3) begin
      tick();
      check("ws.hold", 32'(address16), 32'h00100);
      check("ws.nodone", 32'(d_done8), 32'h0);
    end
    mem_ready = 1;
    tick();
    check("ws.done", 32'(d_done8), 32'h1);
    check("ws.rdata8", 32'(d_rdata8), 32'h00C3);
    check("ws.rdata16", 32'(d_rdata16), 32'h00C3);

    // Jump during a stalled fetch, with q_rd in the same cycle.
    q_rd = 1; mem_ready = 0;
    tick(); tick();
    q_rd = 0;
    tick();
    check("ab.code", 32'(bus_code16), 32'h1);
    jmp = 1; jmp_cs = 16'h2000; jmp_ip = 16'h0100; q_rd = 1; mem_ready = 0;
    tick(); quiet();
    check("ab.empty8", 32'(q_valid8), 32'h0);
    check("ab.empty16", 32'(q_valid16), 32'h0);
    check("ab.bus8", 32'(bus_code8), 32'h0);
    check("ab.q_ip", 32'(q_ip8), 32'h0100);
    tick();
    check("ab.addr8", 32'(address8), 32'h20100);
    check("ab.addr16", 32'(address16), 32'h20100);

    if (WORD_EN) begin
      repeat (12) tick();
      d_req = 1; d_we = 0; d_seg = 16'h3000; d_ea = 16'hFFFF; d_word = 1;
      tick(); quiet();
      tick();
      check("wd.addr0", 32'(address8), 32'h3FFFF);
      tick();
      check("wd.mid", 32'(d_done8), 32'h0);
      tick();
      check("wd.addr1", 32'(address8), 32'h30000);
      check("wd.be16", 32'(be16), 32'h1);
      tick();
      check("wd.done", 32'(d_done8), 32'h1);
      check("wd.rdata8", 32'(d_rdata8), 32'({mem_byte(20'h30000), mem_byte(20'h3FFFF)}));
      check("wd.rdata16", 32'(d_rdata16), 32'({mem_byte(20'h30000), mem_byte(20'h3FFFF)}));
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset_n   = ($urandom_range(0, 499) != 0);
      chipen    = ($urandom_range(0, 9) != 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      jmp       = ($urandom_range(0, 29) == 0);
      jmp_cs    = 16'($urandom);
      jmp_ip    = 16'($urandom);
      q_rd      = 1'($urandom_range(0, 1));
      d_req     = ($urandom_range(0, 7) == 0);
      d_we      = 1'($urandom_range(0, 1));
      d_word    = 1'($urandom_range(0, 1));
      d_seg     = 16'($urandom);
      d_ea      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      d_wdata   = 16'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
